// File: rtl/paddle_input_ctrl.sv
// Frame-rate paddle motion scheduler: chooses between player buttons and a
// ball-tracking autopilot. Direction outputs only change on fsync.
module paddle_input_ctrl #(
    parameter int PADDLE_W    = 200,
    parameter int DEADBAND    = 8,
    parameter int IDLE_FRAMES = 600,
    localparam int CW         = $clog2(IDLE_FRAMES + 1)
) (
    input  logic                 pixel_clk,
    input  logic                 rst,
    input  logic                 fsync,
    input  logic                 pause,
    input  logic                 btn_right,
    input  logic                 btn_left,
    input  logic signed [11:0]   ball_hpos,
    input  logic signed [11:0]   paddle_lhpos,
    output logic                 right,
    output logic                 left,
    output logic                 auto_active,
    output logic [CW-1:0]        idle_cnt
);

    typedef enum logic {ATTRACT, PLAYER} state_t;

    localparam logic [CW-1:0]      IDLE_MAX = CW'(IDLE_FRAMES);
    localparam logic signed [13:0] HALF_W   = 14'(PADDLE_W / 2);
    localparam logic signed [13:0] DB       = 14'(DEADBAND);

    state_t        state_q, state_d;
    logic          right_q, right_d;
    logic          left_q, left_d;
    logic [CW-1:0] idle_q, idle_d;
    logic [1:0]    sync_r_q, sync_l_q;
    logic          act_r_q, act_r_d;
    logic          act_l_q, act_l_d;

    logic          act_r, act_l, any_act;
    logic          ap_right, ap_left;
    logic [CW-1:0] idle_inc;
    logic signed [13:0] ctr, ball_x;

    // Activity seen anywhere in the frame, including the fsync cycle itself
    assign act_r   = act_r_q | sync_r_q[1];
    assign act_l   = act_l_q | sync_l_q[1];
    assign any_act = act_r | act_l;

    // Extra headroom bit keeps centre +/- deadband from wrapping
    assign ctr      = {{2{paddle_lhpos[11]}}, paddle_lhpos} + HALF_W;
    assign ball_x   = {{2{ball_hpos[11]}}, ball_hpos};
    assign ap_right = ball_x > (ctr + DB);
    assign ap_left  = ball_x < (ctr - DB);

    assign idle_inc = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;

    always_comb begin
        state_d = state_q;
        right_d = right_q;
        left_d  = left_q;
        idle_d  = idle_q;
        act_r_d = fsync ? 1'b0 : act_r;
        act_l_d = fsync ? 1'b0 : act_l;
        if (fsync) begin
            right_d = 1'b0;
            left_d  = 1'b0;
            if (!pause) begin
                case (state_q)
                    ATTRACT: begin
                        if (any_act) begin
                            state_d = PLAYER;
                            idle_d  = '0;
                            right_d = act_r & ~act_l;
                            left_d  = act_l & ~act_r;
                        end else begin
                            right_d = ap_right;
                            left_d  = ap_left;
                        end
                    end
                    PLAYER: begin
                        if (any_act) begin
                            idle_d  = '0;
                            right_d = act_r & ~act_l;
                            left_d  = act_l & ~act_r;
                        end else if (idle_inc == IDLE_MAX) begin
                            state_d = ATTRACT;
                            idle_d  = '0;
                        end else begin
                            idle_d  = idle_inc;
                        end
                    end
                    default: state_d = ATTRACT;
                endcase
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q  <= ATTRACT;
            right_q  <= 1'b0;
            left_q   <= 1'b0;
            idle_q   <= '0;
            sync_r_q <= '0;
            sync_l_q <= '0;
            act_r_q  <= 1'b0;
            act_l_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            right_q  <= right_d;
            left_q   <= left_d;
            idle_q   <= idle_d;
            sync_r_q <= {sync_r_q[0], btn_right};
            sync_l_q <= {sync_l_q[0], btn_left};
            act_r_q  <= act_r_d;
            act_l_q  <= act_l_d;
        end
    end

    assign right       = right_q;
    assign left        = left_q;
    assign auto_active = (state_q == ATTRACT);
    assign idle_cnt    = idle_q;

endmodule
